draw_text_box: RTL and testbench
================================

Name: draw_text_box

Overview:
- Parametrised text-overlay stage for the VGA pipeline: draws a COLS x ROWS grid of CHAR_W x CHAR_H glyphs, optionally pixel-doubled, over the incoming video stream.
- Adds runtime box position (latched per frame), opaque or transparent background, per-frame blink and an inverted cursor cell.
- Sits between draw stages on vga_if; the character RAM and font ROM outside the block are addressed through char_xy and char_line.

Parameters:
- CHAR_W, 8, glyph width in pixels (power of 2)
- CHAR_H, 16, glyph height in lines (power of 2)
- COLS, 16, text columns (power of 2)
- ROWS, 16, text rows (power of 2)
- SCALE_LOG2, 0, pixel replication factor is 2^SCALE_LOG2 (0..2)
- X_DEFAULT, 64, box x origin after reset
- Y_DEFAULT, 48, box y origin after reset
- FG_RGB, 12'h000, glyph colour
- BG_RGB, 12'hFFF, background colour used when opaque=1
- BLINK_FRAMES, 30, frames per blink phase (>=1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- cifi  vga_if.in  -  upstream timing and rgb
- cifo  vga_if.out  -  downstream timing and rgb
- xpos  in  11  requested box x origin
- ypos  in  11  requested box y origin
- opaque  in  1  1 = fill non-glyph box pixels with BG_RGB
- blink_en  in  1  1 = glyph pixels hidden during the off phase
- cursor_col  in  log2(COLS)  cursor column
- cursor_row  in  log2(ROWS)  cursor row
- cursor_en  in  1  1 = invert cursor cell (FG and BG swapped), subject to blink
- char_xy  out  log2(ROWS)+log2(COLS)  {row, col} address to the character RAM
- char_line  out  log2(CHAR_H)  glyph line to the font ROM
- char_pixels  in  [0:CHAR_W-1]  glyph row; index 0 is the leftmost pixel

Behaviour:
- Reset: every cifo field is 0, char_xy=0 and char_line=0. Box origin is X_DEFAULT/Y_DEFAULT, frame counter is 0 and blink phase is on (visible).
- Frame event: a cycle where cifi.vblnk=1 and the registered previous vblnk=0.
  - On this event the box origin takes xpos/ypos, so it never changes mid-frame.
  - On this event the frame counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
  - A frame event in the first cycle after reset is honoured.
- Stage 1 (registered): dx = hcount - X0 and dy = vcount - Y0, both 11-bit wrapping.
  - in_box = hcount >= X0 and hcount < X0 + (COLS*CHAR_W << SCALE_LOG2), with the same test on v against ROWS*CHAR_H.
  - in_box also requires hblnk=0 and vblnk=0.
  - u = dx >> SCALE_LOG2 and v = dy >> SCALE_LOG2.
  - char_xy = {v / CHAR_H, u / CHAR_W}; char_line = v mod CHAR_H. Both are driven out of the stage-1 registers.
  - When not in_box, char_xy and char_line still follow the formula (truncated). Consumers ignore them.
  - Glyph column u mod CHAR_W, in_box and is_cursor are carried down the pipeline.
- Stages 2-3: the external RAM and ROM return char_pixels 2 cycles after char_xy/char_line are presented. char_pixels is sampled at stage 3.
- Stage 4 (output register) rgb selection, in priority order:
  - not in_box: delayed cifi.rgb.
  - bit = char_pixels[col], gated by (blink_en=0 or phase on).
  - cursor cell (cursor_en=1, cursor visible under the same blink gating): bit=1 gives BG_RGB, bit=0 gives FG_RGB.
  - otherwise bit=1 gives FG_RGB; bit=0 gives BG_RGB if opaque=1, else delayed cifi.rgb.
- Latency: every cifo field (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb) is exactly 4 cycles behind cifi, with no field reordering.
- Box edges: a box that extends beyond the visible area is clipped naturally by blanking.
  - An origin near 2047 wraps the 11-bit right/bottom edge compare. This is defined behaviour: in_box is empty when the 12-bit sum exceeds 2047; the compare uses 12-bit arithmetic.
- opaque, blink_en and the cursor inputs are sampled at stage 1. They are not latched per frame.

Test Plan:
- Reset, then 10 cycles of streaming → all cifo fields 0 during reset; afterwards cifo mirrors cifi delayed by 4 cycles, with rgb unchanged outside the box.
- Defaults, SCALE_LOG2=0, hcount=90, vcount=85 → char_xy=8'h23 and char_line=5 one cycle later. With the ROM returning 8'b0010_0000 at stage 3, cifo.rgb=12'h000 at cycle 4; for hcount=91, cifo.rgb = pass-through.
- opaque=1, hcount=64..191, vcount=48, all-zero glyphs, input rgb 12'h0F0 → output 12'hFFF for exactly 128 pixels; 12'h0F0 at hcount 63 and 192.
- SCALE_LOG2=1, hcount=64+2*8 and 64+2*8+1 → both give char_xy col=1 and glyph column 0. The box right edge is at hcount 319.
- xpos=200 written mid-frame → the box stays at 64 until the next vblnk rising edge, then starts at 200.
- blink_en=1, BLINK_FRAMES=2, cursor at (2,3) with cursor_en=1 → glyphs shown for 2 frames and hidden for 2 frames. Cell (2,3) shows inverted colours only in visible frames.

Source files
------------

// File: rtl/draw_text_box_if.sv
// rtl/draw_text_box_if.sv - VGA timing and colour bundle passed between draw stages
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_text_box.sv
// rtl/draw_text_box.sv - text grid overlay with per-frame box origin, blink and cursor
module draw_text_box #(
    parameter int          CHAR_W       = 8,
    parameter int          CHAR_H       = 16,
    parameter int          COLS         = 16,
    parameter int          ROWS         = 16,
    parameter int          SCALE_LOG2   = 0,
    parameter int          X_DEFAULT    = 64,
    parameter int          Y_DEFAULT    = 48,
    parameter logic [11:0] FG_RGB       = 12'h000,
    parameter logic [11:0] BG_RGB       = 12'hFFF,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                                    clk,
    input  logic                                    rst,
    vga_if.in                                       cifi,
    vga_if.out                                      cifo,
    input  logic [10:0]                             xpos,
    input  logic [10:0]                             ypos,
    input  logic                                    opaque,
    input  logic                                    blink_en,
    input  logic [$clog2(COLS)-1:0]                 cursor_col,
    input  logic [$clog2(ROWS)-1:0]                 cursor_row,
    input  logic                                    cursor_en,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]    char_xy,
    output logic [$clog2(CHAR_H)-1:0]               char_line,
    input  logic [0:CHAR_W-1]                       char_pixels
);
    localparam int LC    = $clog2(COLS);
    localparam int LR    = $clog2(ROWS);
    localparam int LW    = $clog2(CHAR_W);
    localparam int LH    = $clog2(CHAR_H);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [11:0] BOX_W = 12'(COLS * CHAR_W * (1 << SCALE_LOG2));
    localparam logic [11:0] BOX_H = 12'(ROWS * CHAR_H * (1 << SCALE_LOG2));

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } timing_t;

    typedef struct packed {
        logic          in_box;
        logic [LW-1:0] gcol;
        logic          cursor;
        logic          vis;
        logic          opaque;
    } ctl_t;

    logic [10:0]      x0, y0;
    logic             prev_vblnk;
    logic             phase_on;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_evt;

    assign frame_evt = cifi.vblnk && !prev_vblnk;

    // Origin only moves at the start of vertical blanking so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0         <= 11'(X_DEFAULT);
            y0         <= 11'(Y_DEFAULT);
            prev_vblnk <= 1'b0;
            phase_on   <= 1'b1;
            frame_cnt  <= '0;
        end else begin
            prev_vblnk <= cifi.vblnk;
            if (frame_evt) begin
                x0 <= xpos;
                y0 <= ypos;
                if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    phase_on  <= ~phase_on;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    timing_t     t_in, t1, t2, t3;
    ctl_t        ctl1, ctl2, ctl3;
    logic [10:0] dx, dy, u, v;
    logic [11:0] h_end, v_end;
    logic        in_h, in_v;
    logic [LC-1:0] cell_col;
    logic [LR-1:0] cell_row;

    assign t_in = {cifi.hcount, cifi.vcount, cifi.hsync, cifi.vsync,
                   cifi.hblnk, cifi.vblnk, cifi.rgb};

    assign dx    = cifi.hcount - x0;
    assign dy    = cifi.vcount - y0;
    assign u     = dx >> SCALE_LOG2;
    assign v     = dy >> SCALE_LOG2;
    assign h_end = {1'b0, x0} + BOX_W;
    assign v_end = {1'b0, y0} + BOX_H;

    // An edge past 2047 cannot be reached by an 11-bit counter, so such a box is empty.
    assign in_h = (cifi.hcount >= x0) && ({1'b0, cifi.hcount} < h_end) && !h_end[11];
    assign in_v = (cifi.vcount >= y0) && ({1'b0, cifi.vcount} < v_end) && !v_end[11];

    assign cell_col = LC'(u >> LW);
    assign cell_row = LR'(v >> LH);

    always_ff @(posedge clk) begin
        if (rst) begin
            t1        <= '0;
            t2        <= '0;
            t3        <= '0;
            ctl1      <= '0;
            ctl2      <= '0;
            ctl3      <= '0;
            char_xy   <= '0;
            char_line <= '0;
        end else begin
            t1          <= t_in;
            ctl1.in_box <= in_h && in_v && !cifi.hblnk && !cifi.vblnk;
            ctl1.gcol   <= LW'(u);
            ctl1.cursor <= cursor_en && (cell_col == cursor_col) && (cell_row == cursor_row);
            ctl1.vis    <= !blink_en || phase_on;
            ctl1.opaque <= opaque;
            char_xy     <= {cell_row, cell_col};
            char_line   <= LH'(v);
            t2          <= t1;
            ctl2        <= ctl1;
            t3          <= t2;
            ctl3        <= ctl2;
        end
    end

    // char_pixels lines up with stage 3 because the RAM and ROM add two cycles.
    logic        pix, cur;
    logic [11:0] rgb_next;

    always_comb begin
        pix = char_pixels[ctl3.gcol] && ctl3.vis;
        cur = ctl3.cursor && ctl3.vis;
        if (!ctl3.in_box)
            rgb_next = t3.rgb;
        else if (cur)
            rgb_next = pix ? BG_RGB : FG_RGB;
        else if (pix)
            rgb_next = FG_RGB;
        else if (ctl3.opaque)
            rgb_next = BG_RGB;
        else
            rgb_next = t3.rgb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cifo.hcount <= '0;
            cifo.vcount <= '0;
            cifo.hsync  <= 1'b0;
            cifo.vsync  <= 1'b0;
            cifo.hblnk  <= 1'b0;
            cifo.vblnk  <= 1'b0;
            cifo.rgb    <= '0;
        end else begin
            cifo.hcount <= t3.hcount;
            cifo.vcount <= t3.vcount;
            cifo.hsync  <= t3.hsync;
            cifo.vsync  <= t3.vsync;
            cifo.hblnk  <= t3.hblnk;
            cifo.vblnk  <= t3.vblnk;
            cifo.rgb    <= rgb_next;
        end
    end
endmodule

// File: tb/tb_draw_text_box.sv
// tb/tb_draw_text_box.sv - directed checks of draw_text_box at scale 1 and scale 2
module tb_draw_text_box;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [10:0] xpos, ypos;
    logic        opaque, blink_en, cursor_en;
    logic [3:0]  cursor_col, cursor_row;
    logic [7:0]  char_xy, char_xy_s;
    logic [3:0]  char_line, char_line_s;
    logic [0:7]  font_row, pix_d1, pix_q;

    vga_if cin ();
    vga_if cout ();
    vga_if cout_s ();

    // Two-cycle RAM+ROM stand-in: every cell holds the same glyph row.
    always @(posedge clk) begin
        pix_d1 <= font_row;
        pix_q  <= pix_d1;
    end

    draw_text_box #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .cifi(cin), .cifo(cout),
        .xpos(xpos), .ypos(ypos), .opaque(opaque), .blink_en(blink_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .char_xy(char_xy), .char_line(char_line), .char_pixels(pix_q)
    );

    draw_text_box #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) dut_s (
        .clk(clk), .rst(rst), .cifi(cin), .cifo(cout_s),
        .xpos(xpos), .ypos(ypos), .opaque(opaque), .blink_en(blink_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .char_xy(char_xy_s), .char_line(char_line_s), .char_pixels(pix_q)
    );

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic [11:0] exp;
    } entry_t;

    entry_t q[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [10:0] h, input logic [10:0] v,
                          input logic hb, input logic vb, input logic [11:0] rgb);
        cin.hcount = h;
        cin.vcount = v;
        cin.hsync  = h[0];
        cin.vsync  = v[1];
        cin.hblnk  = hb;
        cin.vblnk  = vb;
        cin.rgb    = rgb;
    endtask

    task automatic compare_front();
        entry_t e;
        e = q.pop_front();
        check($sformatf("stream h=%0d v=%0d", e.h, e.v),
              48'({cout.hcount, cout.vcount, cout.hsync, cout.vsync, cout.hblnk, cout.vblnk, cout.rgb}),
              48'({e.h, e.v, e.h[0], e.v[1], 2'b00, e.exp}));
    endtask

    // Output after the 4th tick belongs to the vector pushed 4 ticks earlier.
    task automatic push(input logic [10:0] h, input logic [10:0] v,
                        input logic [11:0] rgb, input logic [11:0] exp);
        entry_t e;
        set_in(h, v, 1'b0, 1'b0, rgb);
        e.h = h;
        e.v = v;
        e.exp = exp;
        q.push_back(e);
        tick();
        if (q.size() == 4) compare_front();
    endtask

    task automatic drain();
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            compare_front();
        end
    endtask

    task automatic hold(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb);
        set_in(h, v, 1'b0, 1'b0, rgb);
        repeat (4) tick();
    endtask

    task automatic frame();
        set_in(11'd0, 11'd600, 1'b1, 1'b1, 12'h000);
        repeat (2) tick();
        set_in(11'd0, 11'd0, 1'b1, 1'b0, 12'h000);
        tick();
    endtask

    bit vis_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        xpos = 11'd64; ypos = 11'd48;
        opaque = 1'b0; blink_en = 1'b0; cursor_en = 1'b0;
        cursor_col = 4'd0; cursor_row = 4'd0;
        font_row = 8'b0010_0000;
        set_in(11'd123, 11'd45, 1'b0, 1'b0, 12'h777);

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_cifo",
                  48'({cout.hcount, cout.vcount, cout.hsync, cout.vsync, cout.hblnk, cout.vblnk, cout.rgb}),
                  48'd0);
            check("reset_char", 48'({char_xy, char_line}), 48'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            push(11'(400 + i), 11'd300, 12'(i * 273), 12'(i * 273));
        drain();

        push(11'd90, 11'd85, 12'h123, 12'h000);
        check("char_xy_90", 48'(char_xy), 48'h23);
        check("char_line_90", 48'(char_line), 48'd5);
        push(11'd91, 11'd85, 12'h456, 12'h456);
        check("char_xy_91", 48'(char_xy), 48'h23);
        push(11'd88, 11'd85, 12'h789, 12'h789);
        push(11'd200, 11'd85, 12'hABC, 12'hABC);
        drain();

        opaque = 1'b1;
        font_row = 8'h00;
        repeat (2) tick();
        for (int h = 62; h <= 193; h++)
            push(11'(h), 11'd48, 12'h0F0, (h >= 64 && h < 192) ? 12'hFFF : 12'h0F0);
        push(11'd100, 11'd47, 12'h0F0, 12'h0F0);
        push(11'd100, 11'd303, 12'h0F0, 12'hFFF);
        push(11'd100, 11'd304, 12'h0F0, 12'h0F0);
        drain();

        font_row = 8'b1000_0000;
        repeat (2) tick();
        set_in(11'd80, 11'd48, 1'b0, 1'b0, 12'hABC);
        tick();
        check("scale_xy_80", 48'({char_xy_s, char_line_s}), 48'h010);
        repeat (3) tick();
        check("scale_rgb_80", 48'(cout_s.rgb), 48'h000);
        set_in(11'd81, 11'd48, 1'b0, 1'b0, 12'hABC);
        tick();
        check("scale_xy_81", 48'({char_xy_s, char_line_s}), 48'h010);
        repeat (3) tick();
        check("scale_rgb_81", 48'(cout_s.rgb), 48'h000);
        hold(11'd319, 11'd48, 12'hABC);
        check("scale_edge_319", 48'(cout_s.rgb), 48'hFFF);
        hold(11'd320, 11'd48, 12'hABC);
        check("scale_edge_320", 48'(cout_s.rgb), 48'hABC);

        font_row = 8'h00;
        xpos = 11'd200;
        hold(11'd64, 11'd48, 12'h0F0);
        check("xpos_hold_64", 48'(cout.rgb), 48'hFFF);
        hold(11'd200, 11'd48, 12'h0F0);
        check("xpos_hold_200", 48'(cout.rgb), 48'h0F0);
        frame();
        hold(11'd64, 11'd48, 12'h0F0);
        check("xpos_new_64", 48'(cout.rgb), 48'h0F0);
        hold(11'd200, 11'd48, 12'h0F0);
        check("xpos_new_200", 48'(cout.rgb), 48'hFFF);
        hold(11'd199, 11'd48, 12'h0F0);
        check("xpos_new_199", 48'(cout.rgb), 48'h0F0);

        xpos = 11'd64;
        opaque = 1'b0;
        font_row = 8'hFF;
        blink_en = 1'b1;
        cursor_col = 4'd2;
        cursor_row = 4'd3;
        cursor_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            frame();
            hold(11'd64, 11'd48, 12'h0F0);
            check($sformatf("blink_glyph_f%0d", k), 48'(cout.rgb), vis_tab[k] ? 48'h000 : 48'h0F0);
            hold(11'd80, 11'd96, 12'h0F0);
            check($sformatf("blink_cursor_f%0d", k), 48'(cout.rgb), vis_tab[k] ? 48'hFFF : 48'h0F0);
        end
        blink_en = 1'b0;
        hold(11'd64, 11'd48, 12'h0F0);
        check("noblink_glyph", 48'(cout.rgb), 48'h000);
        hold(11'd80, 11'd96, 12'h0F0);
        check("noblink_cursor", 48'(cout.rgb), 48'hFFF);
        cursor_en = 1'b0;
        hold(11'd80, 11'd96, 12'h0F0);
        check("cursor_off", 48'(cout.rgb), 48'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
